// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and receiver.
// Holds the transmit FSM state type, the default bit period and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with a one-cycle tick at terminal count.
// Ports: clk, rst (sync, active-high), restart (hold count at 0), tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (8N1/8N2; 8E1/8E2 with UART_TX_PARITY_EN).
// Ports: clk, rst (sync, active-high), TX_DATA[7:0], TX_EN (rising edge
// starts a frame), TX_STATUS (high = idle/ready), TX (serial line, idles 1).
// Macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       TX
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       en_prev;
  logic       tick;
  logic       rise;
`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  assign rise = TX_EN & ~en_prev;

  // Counter is held at zero while idle so every frame
  // starts with a full-length start bit.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      en_prev   <= 1'b1;
      TX        <= IDLE_LEVEL;
      TX_STATUS <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      en_prev <= TX_EN;
      case (state)
        IDLE: begin
          TX        <= IDLE_LEVEL;
          TX_STATUS <= 1'b1;
          bit_cnt   <= '0;
          if (rise) begin
            shift     <= TX_DATA;
            state     <= START;
            TX        <= START_LEVEL;
            TX_STATUS <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^TX_DATA;
`endif
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            TX      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TX    <= parity_bit;
`else
              state <= STOP;
              TX    <= IDLE_LEVEL;
`endif
            end else begin
              TX      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (tick) begin
            state   <= STOP;
            TX      <= IDLE_LEVEL;
            bit_cnt <= '0;
          end
`else
          state     <= IDLE;
          TX        <= IDLE_LEVEL;
          TX_STATUS <= 1'b1;
`endif
        end
        STOP: begin
          // bit_cnt is reused here to count stop bits
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              state     <= IDLE;
              TX_STATUS <= 1'b1;
              bit_cnt   <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          TX        <= IDLE_LEVEL;
          TX_STATUS <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
// Two instances: CLKS_PER_BIT=4 with STOP_BITS=1 and with STOP_BITS=2.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data2;
  logic       en1, en2;
  logic       st1, st2;
  logic       tx1, tx2;

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .TX_DATA  (data1),
    .TX_EN    (en1),
    .TX_STATUS(st1),
    .TX       (tx1)
  );

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (2)
  ) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .TX_DATA  (data2),
    .TX_EN    (en2),
    .TX_STATUS(st2),
    .TX       (tx2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx();
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic cur_st();
    return (sel == 0) ? st1 : st2;
  endfunction

  task automatic drive_en(input logic e);
    if (sel == 0) en1 = e;
    else en2 = e;
  endtask

  task automatic drive_data(input logic [7:0] d);
    if (sel == 0) data1 = d;
    else data2 = d;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s tx i=%0d", tag, i), cur_tx(), 1'b1);
      chk($sformatf("%s st i=%0d", tag, i), cur_st(), 1'b1);
      tick();
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    drive_data(d);
    drive_en(1'b1);
    tick();
    drive_en(1'b0);
  endtask

  // Called on the first frame cycle; returns on the cycle after the
  // last stop cycle (or after the reset edge when aborting).
  task automatic run_frame(input string tag,
                           input logic [7:0] d,
                           input int stops,
                           input int inj,
                           input int abort);
    logic exp_bits[$];
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (PB == 1) exp_bits.push_back(^d);
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
    for (int k = 0; k < exp_bits.size() * CPB; k++) begin
      chk($sformatf("%s tx k=%0d", tag, k),
          cur_tx(), exp_bits[k / CPB]);
      chk($sformatf("%s st k=%0d", tag, k),
          cur_st(), 1'b0);
      if (k == abort) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      if (k == inj) begin
        drive_en(1'b1);
        drive_data(8'hC3);
      end else if (k == inj + 1) begin
        drive_en(1'b0);
      end
      tick();
    end
    chk({tag, " end st"}, cur_st(), 1'b1);
    chk({tag, " end tx"}, cur_tx(), 1'b1);
  endtask

  initial begin
    rst   = 1'b1;
    en1   = 1'b1;
    en2   = 1'b1;
    data1 = 8'h00;
    data2 = 8'h00;

    // 1: reset with TX_EN already high, no frame after release
    tick();
    chk("rst tx1", tx1, 1'b1);
    chk("rst st1", st1, 1'b1);
    chk("rst tx2", tx2, 1'b1);
    chk("rst st2", st2, 1'b1);
    tick();
    rst = 1'b0;
    sel = 0;
    idle_check("en_hi d1", 8);
    sel = 1;
    idle_check("en_hi d2", 2);
    en1 = 1'b0;
    en2 = 1'b0;
    sel = 0;
    idle_check("idle", 2);

    // 2: basic frame
    pulse(8'hA5);
    run_frame("a5", 8'hA5, 1, -10, -1);
    idle_check("post a5", 3);

    // 3: second pulse mid-frame is ignored, data change ignored
    pulse(8'h3C);
    run_frame("3c", 8'h3C, 1, 12, -1);
    idle_check("post 3c", 8);

    // 4: held TX_EN -> single frame, then back-to-back edge
    drive_data(8'h55);
    drive_en(1'b1);
    tick();
    run_frame("55", 8'h55, 1, -10, -1);
    idle_check("hold", 59 - PB * 4);
    drive_en(1'b0);
    tick();
    pulse(8'h96);
    run_frame("96", 8'h96, 1, -10, -1);
    pulse(8'h0F);
    run_frame("0f b2b", 8'h0F, 1, -10, -1);
    idle_check("post 0f", 2);

    // 5: reset during third data bit aborts the frame
    pulse(8'hE1);
    run_frame("e1 abort", 8'hE1, 1, -10, 13);
    idle_check("abort", 10);
    pulse(8'h5A);
    run_frame("5a", 8'h5A, 1, -10, -1);
    idle_check("post 5a", 2);

    // 6: parity-sensitive data, and two stop bits
    pulse(8'h07);
    run_frame("07", 8'h07, 1, -10, -1);
    idle_check("post 07", 2);
    sel = 1;
    pulse(8'h00);
    run_frame("00 2stop", 8'h00, 2, -10, -1);
    idle_check("post 00", 2);
    pulse(8'hA5);
    run_frame("a5 2stop", 8'hA5, 2, -10, -1);
    idle_check("post a5 2", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
